// File: rtl/imm_extend_pipe.sv
// Registered RV immediate generator for the ID->EX boundary: decodes all base
// immediate formats plus CSR zimm, and carries the result through a 2-entry skid buffer.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      inst,
  input  logic [2:0]       imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_Z   = 3'd6;
  localparam logic [2:0] T_INV = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             valid;
  } entry_t;

  // inst holds instruction bits [31:7], so full-instruction bit k is inst[k-7].
  function automatic logic [XLEN-1:0] decode_imm(input logic [24:0] ib, input logic [2:0] t);
    logic [31:0] imm32;
    case (t)
      T_R:     imm32 = 32'd0;
      T_I:     imm32 = {{20{ib[24]}}, ib[24:13]};
      T_S:     imm32 = {{20{ib[24]}}, ib[24:18], ib[4:0]};
      T_B:     imm32 = {{19{ib[24]}}, ib[24], ib[0], ib[23:18], ib[4:1], 1'b0};
      T_U:     imm32 = {ib[24:5], 12'h000};
      T_J:     imm32 = {{11{ib[24]}}, ib[24], ib[12:5], ib[13], ib[23:14], 1'b0};
      T_Z:     imm32 = {27'd0, ib[12:8]};
      default: imm32 = 32'd0;
    endcase
    return XLEN'({{32{imm32[31]}}, imm32});
  endfunction

  entry_t e0_q, e0_d;
  entry_t e1_q, e1_d;
  logic   in_ready_q, in_ready_d;
  logic   pop;
  logic   accept;
  entry_t new_entry;

  // Skid-buffer next state: flush wins, then refill/shift in FIFO order.
  always_comb begin
    pop               = e0_q.valid && out_ready;
    accept            = in_valid && in_ready_q && !flush;
    new_entry.imm     = decode_imm(inst, imm_type);
    new_entry.tag     = in_tag;
    new_entry.illegal = (imm_type == T_INV);
    new_entry.valid   = 1'b1;
    e0_d              = e0_q;
    e1_d              = e1_q;
    if (flush) begin
      e0_d.valid = 1'b0;
      e1_d.valid = 1'b0;
    end else if (!e0_q.valid || (pop && !e1_q.valid)) begin
      if (accept) begin
        e0_d = new_entry;
      end else begin
        e0_d.valid = 1'b0;
      end
    end else if (pop) begin
      e0_d = e1_q;
      if (accept) begin
        e1_d = new_entry;
      end else begin
        e1_d.valid = 1'b0;
      end
    end else begin
      if (accept) begin
        e1_d = new_entry;
      end else begin
        e1_d = e1_q;
      end
    end
    in_ready_d = !e1_d.valid;
  end

  // State registers; in_ready stays low through the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q       <= '0;
      e1_q       <= '0;
      in_ready_q <= 1'b0;
    end else begin
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = e0_q.valid;
  assign out_imm     = e0_q.imm;
  assign out_tag     = e0_q.tag;
  assign out_illegal = e0_q.illegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe at XLEN=32 and XLEN=64 with a
// queue-based reference model, a format vector table and handshake corner sequences.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [24:0] inst;
  logic [2:0]  imm_type;
  logic [31:0] in_tag;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .imm_type(imm_type), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_ill32));

  imm_extend_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .imm_type(imm_type), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_ill64));

  typedef struct {
    logic [31:0] tag;
    logic [63:0] imm;
    logic        ill;
  } ment_t;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  t;
    logic [63:0] exp;
    logic        ill;
  } vec_t;

  ment_t       mq[$];
  logic [31:0] got_q[$];
  logic        m_rdy = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference immediate from field arithmetic on the full 32-bit instruction.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] t);
    longint s, v;
    s = longint'($signed(w));
    case (t)
      3'd1: v = s >>> 20;
      3'd2: v = (s >>> 25) * 32 + longint'((w >> 7) & 32'h1F);
      3'd3: begin
        v = longint'(w[7]) * 2048 + longint'((w >> 25) & 32'h3F) * 32 + longint'((w >> 8) & 32'hF) * 2;
        if (w[31]) v = v - 64'sd4096;
      end
      3'd4: v = (s >>> 12) * 4096;
      3'd5: begin
        v = longint'((w >> 12) & 32'hFF) * 4096 + longint'(w[20]) * 2048 + longint'((w >> 21) & 32'h3FF) * 2;
        if (w[31]) v = v - 64'sd1048576;
      end
      3'd6: v = longint'((w >> 15) & 32'h1F);
      default: v = 64'sd0;
    endcase
    return v;
  endfunction

  task automatic cycle();
    bit    pop, acc, was_rst;
    ment_t e;
    pop     = (mq.size() > 0) && out_ready;
    acc     = in_valid && m_rdy && !flush;
    was_rst = rst;
    if (out_valid32 && out_ready && !rst) got_q.push_back(out_tag32);
    e.tag = in_tag;
    e.imm = ref_imm({inst, 7'h00}, imm_type);
    e.ill = (imm_type == 3'd7);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_rdy = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      m_rdy = (mq.size() < 2);
    end
    #1;
    chk("out_valid", out_valid32, 64'(mq.size() > 0));
    chk("in_ready", in_ready32, 64'(m_rdy));
    chk("out_valid64", out_valid64, 64'(mq.size() > 0));
    chk("in_ready64", in_ready64, 64'(m_rdy));
    if (mq.size() > 0) begin
      chk("imm32", out_imm32, {32'd0, mq[0].imm[31:0]});
      chk("imm64", out_imm64, mq[0].imm);
      chk("tag", out_tag32, 64'(mq[0].tag));
      chk("tag64", out_tag64, 64'(mq[0].tag));
      chk("illegal", out_ill32, 64'(mq[0].ill));
      chk("illegal64", out_ill64, 64'(mq[0].ill));
    end
    if (was_rst) begin
      chk("rst_imm32", out_imm32, 64'd0);
      chk("rst_imm64", out_imm64, 64'd0);
      chk("rst_tag", out_tag32, 64'd0);
      chk("rst_illegal", out_ill32, 64'd0);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] t, input logic [31:0] tg);
    in_valid = v;
    inst     = w[31:7];
    imm_type = t;
    in_tag   = tg;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2] = '{32'h0080006F, 3'd5, 64'h0000000000000008, 1'b0};
    vecs[3] = '{32'hFE112E23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[4] = '{32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5] = '{32'h300FD0F3, 3'd6, 64'h000000000000001F, 1'b0};
    vecs[6] = '{32'hDEADBEEF, 3'd7, 64'h0000000000000000, 1'b1};
    vecs[7] = '{32'hFFFFFFB3, 3'd0, 64'h0000000000000000, 1'b0};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    cycle();
    cycle();
    chk("reset_out_valid", out_valid32, 64'd0);
    chk("reset_in_ready", in_ready32, 64'd0);
    rst = 1'b0;
    cycle();
    chk("post_reset_in_ready", in_ready32, 64'd1);

    // Format table, back to back with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].inst, vecs[i].t, 32'(100 + i));
      cycle();
      chk("vec_valid", out_valid32, 64'd1);
      chk("vec_imm32", out_imm32, {32'd0, vecs[i].exp[31:0]});
      chk("vec_imm64", out_imm64, vecs[i].exp);
      chk("vec_illegal", out_ill32, 64'(vecs[i].ill));
      chk("vec_tag", out_tag32, 64'(100 + i));
    end
    drain();

    // Back-pressure: tags 1..4 with out_ready low for 3 cycles.
    got_q.delete();
    out_ready = 1'b0;
    begin
      int next_tag;
      next_tag = 1;
      for (int c = 0; c < 20 && next_tag <= 4; c++) begin
        if (c == 3) out_ready = 1'b1;
        drive(1'b1, $urandom, 3'd1, 32'(next_tag));
        if (m_rdy) next_tag++;
        cycle();
        if (c == 1) chk("bp_in_ready_low", in_ready32, 64'd0);
        if (c == 2) chk("bp_hold_tag", out_tag32, 64'd1);
      end
      chk("bp_all_accepted", 64'(next_tag), 64'd5);
    end
    drain();
    chk("bp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < got_q.size() && i < 4; i++) chk("bp_order", 64'(got_q[i]), 64'(i + 1));

    // Flush with both entries full and a same-cycle input.
    got_q.delete();
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd1, 32'hA1); cycle();
    drive(1'b1, 32'h00200093, 3'd1, 32'hA2); cycle();
    chk("full_in_ready", in_ready32, 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00300093, 3'd1, 32'hDEAD);
    cycle();
    flush = 1'b0;
    chk("flush_out_valid", out_valid32, 64'd0);
    chk("flush_in_ready", in_ready32, 64'd1);
    drain();
    chk("flush_no_output", 64'(got_q.size()), 64'd0);

    // Flush together with a pop: the popped entry is consumed, nothing remains.
    got_q.delete();
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 3'd1, 32'hB1); cycle();
    out_ready = 1'b1; flush = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    cycle();
    flush = 1'b0;
    chk("flushpop_out_valid", out_valid32, 64'd0);
    drain();
    chk("flushpop_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("flushpop_tag", 64'(got_q[0]), 64'hB1);

    // Reset pulse mid-stream with E1 full.
    out_ready = 1'b0;
    drive(1'b1, 32'h00700093, 3'd1, 32'hC1); cycle();
    drive(1'b1, 32'h00800093, 3'd1, 32'hC2); cycle();
    rst = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    cycle();
    chk("midrst_out_valid", out_valid32, 64'd0);
    chk("midrst_in_ready", in_ready32, 64'd0);
    chk("midrst_imm", out_imm32, 64'd0);
    chk("midrst_tag", out_tag32, 64'd0);
    rst = 1'b0;
    cycle();
    got_q.delete();
    out_ready = 1'b1;
    drive(1'b1, 32'h00900093, 3'd1, 32'h77); cycle();
    drain();
    chk("midrst_first_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("midrst_first_tag", 64'(got_q[0]), 64'h77);

    // Randomized traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate generator for the ID→EX boundary of the RV core. It decodes the immediate from instruction bits [31:7] for all base formats plus the CSR zimm format, and sign-extends to XLEN (32 or 64). The result travels with a caller-defined tag through a 2-entry valid/ready skid buffer, so a stalled EX stage never loses or duplicates an immediate. A flush input drops in-flight entries on branch mispredict or trap.

## Interface
- XLEN, 32: datapath width. Only 32 or 64 are legal; any other value is an elaboration error.
- TAG_W, 32: width of the passthrough tag, typically PC or PC+rd.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered entries and the same-cycle input.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  block can accept this cycle.
- inst  in  25  instruction bits [31:7].
- imm_type  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 invalid.
- in_tag  in  TAG_W  passthrough data.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream consumes when high with out_valid.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag captured with the entry.
- out_illegal  out  1  entry had imm_type 7.

## Operation
- Decode is combinational on the input side; results are registered. Bit numbering below refers to the full instruction.
  - R: 0.
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: sext({inst[31:12], 12'b0}). With XLEN=64, bits 63:32 copy bit 31.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Z: zero-extend inst[19:15].
  - Type 7: out_imm 0 and out_illegal 1. Every other type sets out_illegal 0.
- sext always extends to XLEN from the format's sign bit, which is inst[31].
- Storage has two entries. E0 is the output register and drives out_*. E1 is the skid register. Each entry holds {imm, tag, illegal, valid}.
- in_ready = !E1.valid. It is registered state, with no combinational path from out_ready.
- Accept occurs when in_valid && in_ready && !flush.
- Per-cycle update, where pop = out_valid && out_ready:
  - E0 empty, or pop with E1 empty: an accepted input loads E0.
  - pop with E1 valid: E1 moves to E0. An accepted input loads E1.
  - No pop and E0 valid: an accepted input loads E1.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush or rst.
- Flush has priority over accept and pop. At the next edge both valids are 0 and the same-cycle input is discarded. Data fields are don't-care after flush.
- rst has priority over flush.

## Timing
- Latency: accept on edge N puts out_valid high after edge N when the buffer was empty.
- Throughput: 1 per cycle while out_ready is held high. E1 stays empty in that case.
- Back-pressure: after one cycle with out_ready low and continued input, E1 fills and in_ready drops in the following cycle. in_ready rises the cycle after the first pop.
- Reset state while rst is high and at the first edge after it:
  - out_valid 0, in_ready 0.
  - out_imm 0, out_tag 0, out_illegal 0.
  - E1 empty.
  - in_ready becomes 1 in the first cycle after rst deasserts.
- rst asserted mid-stream clears both entries at that edge. No stale output appears after release.
- Flush while full: out_valid 0 and in_ready 1 in the next cycle.
- Flush and pop in the same cycle: the consumer takes the E0 data, and nothing remains afterwards.
- out_imm and out_tag hold stable while out_valid && !out_ready.

## Test plan
- Formats at XLEN=32, out_ready held 1, one instruction per cycle. Each out_imm appears one cycle after accept, back to back:
  - 0xFFF00093, I → 0xFFFFFFFF.
  - 0xFE000EE3, B → 0xFFFFFFFC.
  - 0x0080006F, J → 0x00000008.
  - 0xFE112E23 (sw x1,-4(x2)), S → 0xFFFFFFFC.
  - 0x800000B7, U → 0x80000000.
  - CSR inst with rs1 field 31, Z → 0x0000001F.
- XLEN=64 with 0x800000B7, U → out_imm 0xFFFFFFFF80000000. The same ADDI case → 0xFFFFFFFFFFFFFFFF.
- Back-pressure: stream tags 1,2,3,4 with out_ready low for 3 cycles.
  - in_ready drops after tags 1 and 2 are held.
  - On release, outputs are 1,2,3,4 in order with no gaps or duplicates.
- imm_type 7 with any inst → out_illegal 1 and out_imm 0. A following R-type → out_illegal 0 and out_imm 0.
- Flush with both entries full plus a same-cycle valid input:
  - Next cycle out_valid 0 and in_ready 1.
  - The discarded tag never appears at the output.
- rst pulsed for 1 cycle mid-stream with E1 full:
  - All outputs read 0 and in_ready is 0 during reset.
  - The first post-reset input is the first output.
